// File: rtl/atan_rom_arb.sv
// Shared atan(2^-i) table serving CHANNELS requesters through a round-robin arbiter,
// with LATENCY-deep result delivery. Define ATAN_ROM_RANGE_CHECK_EN to add the rd_err output.
module atan_rom_arb #(
   parameter int WORD_LENGTH    = 16,
   parameter int ADDRESS_LENGTH = 4,
   parameter int MEMORY_DEPTH   = 16,
   parameter int CHANNELS       = 2,
   parameter int LATENCY        = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               read_enable,
   input  logic [CHANNELS-1:0]                rd_req,
   input  logic [CHANNELS*ADDRESS_LENGTH-1:0] rd_addr,
   output logic [CHANNELS-1:0]                rd_gnt,
   output logic [CHANNELS-1:0]                rd_valid,
   output logic [CHANNELS*WORD_LENGTH-1:0]    rd_data,
`ifdef ATAN_ROM_RANGE_CHECK_EN
   output logic [CHANNELS-1:0]                rd_err,
`endif
   output logic                               busy
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef struct packed {
      logic                   vld;
`ifdef ATAN_ROM_RANGE_CHECK_EN
      logic                   err;
`endif
      logic [CH_W-1:0]        ch;
      logic [WORD_LENGTH-1:0] dat;
   } stage_t;

   // Degrees x 256, rounded to nearest.
   function automatic logic [15:0] base_atan(input int idx);
      case (idx)
         0:       return 16'd11520;
         1:       return 16'd6801;
         2:       return 16'd3593;
         3:       return 16'd1824;
         4:       return 16'd916;
         5:       return 16'd458;
         6:       return 16'd229;
         7:       return 16'd115;
         8:       return 16'd57;
         9:       return 16'd29;
         10:      return 16'd14;
         11:      return 16'd7;
         12:      return 16'd4;
         13:      return 16'd2;
         14:      return 16'd1;
         default: return 16'd0;
      endcase
   endfunction

   logic [CH_W-1:0]                 rr_q, rr_d;
   stage_t                          s0, fin;
   logic                            pipe_busy;
   logic [CHANNELS-1:0]             rd_valid_q, rd_valid_d;
   logic [CHANNELS*WORD_LENGTH-1:0] rd_data_q, rd_data_d;
`ifdef ATAN_ROM_RANGE_CHECK_EN
   logic [CHANNELS-1:0]             rd_err_q, rd_err_d;
`endif

   always_comb begin : arbiter
      logic found;
      int   sel;
      int   a;
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      rd_gnt = '0;
      found  = 1'b0;
      sel    = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         int idx;
         idx = (int'(rr_q) + i) % CHANNELS;
         if (read_enable && !found && rd_req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      if (found) rd_gnt = CHANNELS'(1) << sel;
      rr_d = found ? CH_W'((sel + 1) % CHANNELS) : rr_q;

      // Table read for the granted channel; its result enters stage 1.
      a      = int'(rd_addr[sel*ADDRESS_LENGTH +: ADDRESS_LENGTH]);
      s0     = '0;
      s0.vld = found;
      s0.ch  = CH_W'(sel);
      if (a < MEMORY_DEPTH) s0.dat[WORD_LENGTH-1 -: 16] = base_atan(a);
`ifdef ATAN_ROM_RANGE_CHECK_EN
      s0.err = found && (a >= MEMORY_DEPTH);
`endif
   end

   generate
      if (LATENCY > 1) begin : g_pipe
         stage_t pipe_q [LATENCY-1];
         stage_t pipe_d [LATENCY-1];

         always_comb begin
            pipe_d[0] = s0;
            for (int i = 1; i < LATENCY-1; i++) pipe_d[i] = pipe_q[i-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < LATENCY-1; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q <= pipe_d;
            end
         end

         always_comb begin
            pipe_busy = 1'b0;
            for (int i = 0; i < LATENCY-1; i++) pipe_busy = pipe_busy | pipe_q[i].vld;
         end

         assign fin = pipe_q[LATENCY-2];
      end else begin : g_bypass
         assign fin       = s0;
         assign pipe_busy = 1'b0;
      end
   endgenerate

   // Only the delivered channel's holding register changes.
   always_comb begin : deliver
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
`ifdef ATAN_ROM_RANGE_CHECK_EN
      rd_err_d   = '0;
`endif
      if (fin.vld) begin
         rd_valid_d = CHANNELS'(1) << fin.ch;
         rd_data_d[int'(fin.ch)*WORD_LENGTH +: WORD_LENGTH] = fin.dat;
`ifdef ATAN_ROM_RANGE_CHECK_EN
         if (fin.err) rd_err_d = CHANNELS'(1) << fin.ch;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q       <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
`ifdef ATAN_ROM_RANGE_CHECK_EN
         rd_err_q   <= '0;
`endif
      end else begin
         // NOTE: state updates use <= so every flop samples pre-edge values.
         rr_q       <= rr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
`ifdef ATAN_ROM_RANGE_CHECK_EN
         rd_err_q   <= rd_err_d;
`endif
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign busy     = pipe_busy | (|rd_valid_q);
`ifdef ATAN_ROM_RANGE_CHECK_EN
   assign rd_err   = rd_err_q;
`endif

endmodule

// File: tb/tb_atan_rom_arb.sv
// Scoreboard bench for atan_rom_arb: instance A (depth 12, latency 2) and B (20-bit, latency 4).
// Honors ATAN_ROM_RANGE_CHECK_EN to also check rd_err.
module tb_atan_rom_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic        rst_a, en_a, busy_a;
   logic [1:0]  req_a, gnt_a, valid_a, err_a;
   logic [7:0]  addr_a;
   logic [31:0] data_a;

   logic        rst_b, en_b, busy_b;
   logic [1:0]  req_b, gnt_b, valid_b, err_b;
   logic [7:0]  addr_b;
   logic [39:0] data_b;

   atan_rom_arb #(.WORD_LENGTH(16), .ADDRESS_LENGTH(4), .MEMORY_DEPTH(12), .CHANNELS(2), .LATENCY(2)) u_a (
      .clk(clk), .rst_n(rst_a), .read_enable(en_a), .rd_req(req_a), .rd_addr(addr_a),
      .rd_gnt(gnt_a), .rd_valid(valid_a), .rd_data(data_a),
`ifdef ATAN_ROM_RANGE_CHECK_EN
      .rd_err(err_a),
`endif
      .busy(busy_a));

   atan_rom_arb #(.WORD_LENGTH(20), .ADDRESS_LENGTH(4), .MEMORY_DEPTH(16), .CHANNELS(2), .LATENCY(4)) u_b (
      .clk(clk), .rst_n(rst_b), .read_enable(en_b), .rd_req(req_b), .rd_addr(addr_b),
      .rd_gnt(gnt_b), .rd_valid(valid_b), .rd_data(data_b),
`ifdef ATAN_ROM_RANGE_CHECK_EN
      .rd_err(err_b),
`endif
      .busy(busy_b));

`ifndef ATAN_ROM_RANGE_CHECK_EN
   assign err_a = 2'b00;
   assign err_b = 2'b00;
`endif

   int base_tbl [16] = '{11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7, 4, 2, 1, 0};

   function automatic logic [63:0] exp_val(input int addr, input int depth, input int shift);
      if (addr < depth && addr < 16) return 64'(base_tbl[addr]) << shift;
      return 64'd0;
   endfunction

   typedef struct {
      int         ch;
      logic [63:0] data;
      int         due;
      bit         err;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [63:0] hold_a [2];
   logic [63:0] hold_b [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor A: pop one expectation per delivered result and compare everything visible.
   always @(negedge clk) begin
      if (!rst_a) begin
         hold_a[0] = '0;
         hold_a[1] = '0;
      end else if (valid_a != 2'b00) begin
         logic [1:0] eerr;
         eerr = 2'b00;
         for (int c = 0; c < 2; c++) begin
            if (valid_a[c]) begin
               if (qa.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL a_unexpected_valid actual=ch%0d required=none (cycle %0d)", c, cyc);
               end else begin
                  exp_t e;
                  e = qa.pop_front();
                  check("a_valid_ch", 64'(c), 64'(e.ch));
                  check("a_valid_cycle", 64'(cyc), 64'(e.due));
                  hold_a[e.ch] = e.data;
                  eerr[e.ch]   = e.err;
               end
            end
         end
         check("a_rd_data", 64'(data_a), 64'({hold_a[1][15:0], hold_a[0][15:0]}));
`ifdef ATAN_ROM_RANGE_CHECK_EN
         check("a_rd_err", 64'(err_a), 64'(eerr));
`endif
      end
   end

   always @(negedge clk) begin
      if (!rst_b) begin
         hold_b[0] = '0;
         hold_b[1] = '0;
      end else if (valid_b != 2'b00) begin
         logic [1:0] eerr;
         eerr = 2'b00;
         for (int c = 0; c < 2; c++) begin
            if (valid_b[c]) begin
               if (qb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL b_unexpected_valid actual=ch%0d required=none (cycle %0d)", c, cyc);
               end else begin
                  exp_t e;
                  e = qb.pop_front();
                  check("b_valid_ch", 64'(c), 64'(e.ch));
                  check("b_valid_cycle", 64'(cyc), 64'(e.due));
                  hold_b[e.ch] = e.data;
                  eerr[e.ch]   = e.err;
               end
            end
         end
         check("b_rd_data", 64'(data_b), 64'({hold_b[1][19:0], hold_b[0][19:0]}));
`ifdef ATAN_ROM_RANGE_CHECK_EN
         check("b_rd_err", 64'(err_b), 64'(eerr));
`endif
      end
   end

   // One cycle of stimulus on A; exp_gnt is the hand-derived round-robin grant.
   task automatic drive_a(input logic en, input logic [1:0] req, input int a0, input int a1,
                          input logic [1:0] exp_gnt, input bit push = 1'b1);
      exp_t e;
      en_a   = en;
      req_a  = req;
      addr_a = {4'(a1), 4'(a0)};
      @(negedge clk);
      check("a_rd_gnt", 64'(gnt_a), 64'(exp_gnt));
      for (int c = 0; c < 2; c++) begin
         if (exp_gnt[c] && push) begin
            e.ch   = c;
            e.data = exp_val(c ? a1 : a0, 12, 0);
            e.err  = ((c ? a1 : a0) >= 12);
            e.due  = cyc + 2;
            qa.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_b(input logic [1:0] req, input int a0, input int a1, input logic [1:0] exp_gnt);
      exp_t e;
      req_b  = req;
      addr_b = {4'(a1), 4'(a0)};
      @(negedge clk);
      check("b_rd_gnt", 64'(gnt_b), 64'(exp_gnt));
      for (int c = 0; c < 2; c++) begin
         if (exp_gnt[c]) begin
            e.ch   = c;
            e.data = exp_val(c ? a1 : a0, 16, 4);
            e.err  = 1'b0;
            e.due  = cyc + 4;
            qb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a(input int n);
      en_a  = 1'b1;
      req_a = 2'b00;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst_a();
      req_a = 2'b00;
      rst_a = 1'b0;
      @(posedge clk);
      #1;
      rst_a = 1'b1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b0; en_a = 1'b0; req_a = '0; addr_a = '0;
      rst_b = 1'b0; en_b = 1'b0; req_b = '0; addr_b = '0;
      @(negedge clk);
      check("a_reset_valid", 64'(valid_a), 64'd0);
      check("a_reset_data",  64'(data_a),  64'd0);
      check("a_reset_busy",  64'(busy_a),  64'd0);
      check("b_reset_valid", 64'(valid_b), 64'd0);
      check("b_reset_data",  64'(data_b),  64'd0);
      check("b_reset_busy",  64'(busy_b),  64'd0);
      @(posedge clk);
      #1;
      rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;

      // Single channel: ch0 addr 2 -> 3593 two cycles later, ch1 stays 0.
      drive_a(1'b1, 2'b01, 2, 0, 2'b01);
      req_a = 2'b00;
      @(negedge clk);
      check("a_busy_inflight", 64'(busy_a), 64'd1);
      @(posedge clk);
      #1;
      idle_a(4);
      @(negedge clk);
      check("a_busy_idle", 64'(busy_a), 64'd0);
      @(posedge clk);
      #1;

      // Contention from reset, then back-to-back grants to a lone requester.
      pulse_rst_a();
      drive_a(1'b1, 2'b11, 0, 1, 2'b01);
      drive_a(1'b1, 2'b11, 0, 1, 2'b10);
      drive_a(1'b1, 2'b11, 0, 1, 2'b01);
      drive_a(1'b1, 2'b11, 0, 1, 2'b10);
      drive_a(1'b1, 2'b01, 0, 1, 2'b01);
      drive_a(1'b1, 2'b01, 0, 1, 2'b01);
      idle_a(3);

      // Enable low blocks grants; first grant after raising goes to ch0.
      pulse_rst_a();
      drive_a(1'b0, 2'b11, 3, 5, 2'b00);
      drive_a(1'b0, 2'b11, 3, 5, 2'b00);
      drive_a(1'b1, 2'b11, 3, 5, 2'b01);
      drive_a(1'b1, 2'b11, 3, 5, 2'b10);
      // A lookup in flight survives enable dropping.
      drive_a(1'b1, 2'b01, 6, 5, 2'b01);
      drive_a(1'b0, 2'b11, 6, 5, 2'b00);
      drive_a(1'b0, 2'b11, 6, 5, 2'b00);
      idle_a(2);

      // Out of range at depth 12: 13 and 12 read 0, 11 reads 7.
      drive_a(1'b1, 2'b01, 13, 0, 2'b01);
      drive_a(1'b1, 2'b10, 0, 11, 2'b10);
      drive_a(1'b1, 2'b01, 12, 0, 2'b01);
      idle_a(3);

      // Reset one cycle after a grant drops that lookup.
      drive_a(1'b1, 2'b10, 0, 4, 2'b10, 1'b0);
      req_a = 2'b00;
      rst_a = 1'b0;
      @(negedge clk);
      check("a_midrst_valid", 64'(valid_a), 64'd0);
      check("a_midrst_data",  64'(data_a),  64'd0);
      check("a_midrst_busy",  64'(busy_a),  64'd0);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      idle_a(4);
      @(negedge clk);
      check("a_postrst_data", 64'(data_a), 64'd0);
      check("a_postrst_busy", 64'(busy_a), 64'd0);
      @(posedge clk);
      #1;

      // Wide word, latency 4: addr 3 -> 29184, addr 14 -> 16.
      drive_b(2'b01, 3, 0, 2'b01);
      drive_b(2'b10, 0, 14, 2'b10);
      req_b = 2'b00;

      for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
      @(negedge clk);
      check("a_queue_drained", 64'(qa.size()), 64'd0);
      check("b_queue_drained", 64'(qb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
